vga_timing: RTL
===============

// Module: vga_timing
// PURPOSE
//  Raster timing generator feeding all screen objects (ball, paddles, score) and the pixel mixer.
//  Divides the 50 MHz board clock into a pixel-enable strobe.
//  Produces 11-bit hcount/vcount, registered sync and blank flags, and a frame_start pulse.
//  Default timing is 640x480@60. vblank is glitch-free because downstream logic edge-detects it once per frame.
// PARAMETERS
//  CLK_DIV    2    clk cycles per pixel (>=1)
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch, pixels
//  H_SYNC     96   hsync width, pixels
//  H_BP       48   horizontal back porch, pixels
//  V_ACTIVE   480  visible lines
//  V_FP       10   vertical front porch, lines
//  V_SYNC     2    vsync width, lines
//  V_BP       33   vertical back porch, lines
//  HSYNC_POL  0    active level of hsync
//  VSYNC_POL  0    active level of vsync
// PORTS
//  clk          in   1   system clock, 50 MHz
//  rst          in   1   synchronous reset, active-high
//  pix_en       out  1   one-clk pixel strobe, 1 of every CLK_DIV clks
//  hcount       out  11  pixel column, 0..H_TOTAL-1
//  vcount       out  11  line, 0..V_TOTAL-1
//  hsync        out  1   horizontal sync, polarity HSYNC_POL
//  vsync        out  1   vertical sync, polarity VSYNC_POL
//  hblank       out  1   high while hcount >= H_ACTIVE
//  vblank       out  1   high while vcount >= V_ACTIVE
//  blank        out  1   hblank | vblank
//  frame_start  out  1   one-clk pulse when counters wrap to (0,0)
// BEHAVIOUR
//  - Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//    Both must be <=2048; elaboration fails otherwise.
//  - Reset values: counts 0, pix_en 0, blanks 0, frame_start 0, div counter 0.
//    hsync=~HSYNC_POL and vsync=~VSYNC_POL (inactive).
//  - rst overrides everything, including mid-frame. Next cycle shows reset values.
//    The restart begins at (0,0) with no frame_start pulse.
//  - Divider: div_cnt counts 0..CLK_DIV-1 and wraps.
//    pix_en is registered high on the edge where div_cnt wraps.
//    After reset release, pix_en is low for CLK_DIV-1 clks, then high 1 clk, repeating.
//    For CLK_DIV=1, pix_en is constant 1 from the first clk after reset.
//  - Counters advance only on edges where pix_en==1, so each count holds CLK_DIV clks.
//    hcount wraps H_TOTAL-1 -> 0. vcount increments only on that wrap.
//    vcount wraps V_TOTAL-1 -> 0 on the same edge.
//  - All flags are decoded from next-count values and registered, so they are aligned with hcount/vcount (zero lag).
//    - hsync active: H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
//    - vsync active: V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, for whole lines.
//  - vblank rises exactly once per frame, at (0,V_ACTIVE), and falls at (0,0). No other transitions.
//  - frame_start is high for exactly the first clk in which counts equal (0,0) after a natural wrap.
// STRUCTURE
//  - Shared defs.v gains the default timing macros (`VGA_H_ACTIVE ... `VGA_V_BP).
//    The default parameters take their values from these macros.
//    The TABLE_* bounds stay within `VGA_H_ACTIVE/`VGA_V_ACTIVE.
//  - Sub-module pix_en_div (parameter CLK_DIV; ports clk, rst, en): the divider.
//    Counters and sync/blank decode stay in vga_timing.
// TESTING
//  1. Defaults, reset, run 2 frames.
//     - hcount 799->0 wrap; vcount 524->0 wrap.
//     - Frame period exactly 800*525*2 = 840000 clks.
//  2. Defaults.
//     - hsync low exactly for hcount 656..751 (96 px, 192 clks).
//     - vsync low exactly for vcount 490..491.
//     - hsync/vsync high everywhere else.
//  3. Defaults, 3 frames.
//     - vblank has exactly one rising edge per frame, coincident with (0,480).
//     - It falls at (0,0). blank == hblank|vblank every clk.
//  4. rst for 1 clk at (300,200).
//     - Next clk: counts 0, syncs inactive, blanks 0, pix_en 0, frame_start 0.
//     - Then pix_en 0,1,0,1...
//  5. CLK_DIV=1, H 8/2/2/2, V 4/1/1/1.
//     - pix_en constant 1; frame_start every 14*7 = 98 clks, 1 clk wide.
//     - hsync active at hcount 10..11.
//  6. Defaults.
//     - frame_start never asserted on the first frame after reset.
//     - Thereafter exactly one 1-clk pulse per 840000 clks, while hcount=vcount=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared raster-timing definitions: counter widths, default 640x480@60 timing,
// the registered flag bundle and a window-decode helper.
package vga_timing_pkg;

    localparam int unsigned CNT_W     = 11;   // hcount/vcount width
    localparam int unsigned CMP_W     = 12;   // compare width; a window end may equal 2048
    localparam int unsigned MAX_TOTAL = 2048;

    // Default 640x480@60 timing
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblank;
        logic vblank;
    } vga_flags_t;

    // True when start <= pos < stop
    function automatic logic in_window(input logic [CMP_W-1:0] pos,
                                       input logic [CMP_W-1:0] start,
                                       input logic [CMP_W-1:0] stop);
        return (pos >= start) && (pos < stop);
    endfunction

endpackage

// File: rtl/vga_timing_pix_en_div.sv
// Pixel-enable divider: en is a one-clk strobe once every CLK_DIV clks.
// Ports: clk, rst (sync, active-high), en (registered strobe).
module pix_en_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic en
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // en is registered on the edge where div_cnt wraps; CLK_DIV=1 keeps it at 1
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            en      <= 1'b0;
        end else begin
            en <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: pixel-enable divider, h/v counters and registered
// sync/blank/frame_start flags aligned with the counts.
// Ports: clk, rst (sync, active-high); pix_en strobe; hcount/vcount (11b);
// hsync/vsync (polarity by parameter); hblank/vblank/blank; frame_start pulse.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             pix_en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblank,
    output logic             vblank,
    output logic             blank,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $error("vga_timing: H_TOTAL/V_TOTAL must not exceed 2048");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing: CLK_DIV must be at least 1");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CMP_W-1:0] HS_START = CMP_W'(H_ACTIVE + H_FP);
    localparam logic [CMP_W-1:0] HS_END   = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CMP_W-1:0] VS_START = CMP_W'(V_ACTIVE + V_FP);
    localparam logic [CMP_W-1:0] VS_END   = CMP_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CMP_W-1:0] H_ACT_C  = CMP_W'(H_ACTIVE);
    localparam logic [CMP_W-1:0] V_ACT_C  = CMP_W'(V_ACTIVE);

    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             frame_wrap;
    vga_flags_t       flags_next;

    pix_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .en  (pix_en)
    );

    // Next counts, plus flags decoded from them so registered flags line up with counts
    always_comb begin
        h_next     = hcount;
        v_next     = vcount;
        frame_wrap = 1'b0;
        if (pix_en) begin
            if (hcount == H_LAST) begin
                h_next = '0;
                if (vcount == V_LAST) begin
                    v_next     = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_next = vcount + CNT_W'(1);
                end
            end else begin
                h_next = hcount + CNT_W'(1);
            end
        end
        flags_next.hsync  = in_window({1'b0, h_next}, HS_START, HS_END) ? HSYNC_POL : ~HSYNC_POL;
        flags_next.vsync  = in_window({1'b0, v_next}, VS_START, VS_END) ? VSYNC_POL : ~VSYNC_POL;
        flags_next.hblank = ({1'b0, h_next} >= H_ACT_C);
        // vblank depends on vcount only, so it cannot toggle mid-line
        flags_next.vblank = ({1'b0, v_next} >= V_ACT_C);
    end

    // Count and flag registers; reset restarts at (0,0) without a frame_start pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            hblank      <= 1'b0;
            vblank      <= 1'b0;
            blank       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_next;
            vcount      <= v_next;
            hsync       <= flags_next.hsync;
            vsync       <= flags_next.vsync;
            hblank      <= flags_next.hblank;
            vblank      <= flags_next.vblank;
            blank       <= flags_next.hblank | flags_next.vblank;
            frame_start <= frame_wrap;
        end
    end

endmodule
